// File: rtl/shift_reg_controller_pkg.sv
// Shared definitions for the shift-register sequencer: default sizes and the
// controller state encoding.
package shift_reg_controller_pkg;

  // Default shift register width and the counter width that indexes it.
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 3;

  // Controller states; encodings are fixed so waveforms read the same everywhere.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // True for every state in which a transfer is in flight.
  function automatic logic state_is_busy(input state_t s);
    return (s == S_SHIFT) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/shift_reg_controller_if.sv
// Requester-side bus of the shift-register sequencer.
//   master : the requesting FSM/testbench (drives start, tx_data, rx_bit)
//   slave  : the sequencer (drives busy, done, tx_bit, tx_valid, rx_data)
//   start    request a transfer (sampled only while idle)
//   tx_data  word to transmit, sampled with an accepted start
//   rx_bit   serial receive bit, sampled at each shift edge
//   busy     transfer in flight (shift and done cycles)
//   done     one-cycle pulse; rx_data valid in that cycle
//   tx_bit   current serial transmit bit
//   tx_valid tx_bit carries a data bit
//   rx_data  received word
interface shift_reg_controller_if
  import shift_reg_controller_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             rx_bit;
  logic             busy;
  logic             done;
  logic             tx_bit;
  logic             tx_valid;
  logic [WIDTH-1:0] rx_data;

  modport master (
    output start, tx_data, rx_bit,
    input  busy, done, tx_bit, tx_valid, rx_data
  );

  modport slave (
    input  start, tx_data, rx_bit,
    output busy, done, tx_bit, tx_valid, rx_data
  );

endinterface

// File: rtl/shift_reg_controller_bit_counter.sv
// Shift-cycle counter for the sequencer.
//   clk        rising-edge clock
//   clear      synchronous clear to zero (priority over en)
//   en         count up by one
//   terminal_c combinational flag: count equals LAST
module bit_counter
  import shift_reg_controller_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned LAST  = DEF_WIDTH - 1
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  output logic terminal_c
);

  logic [CNT_W-1:0] cnt;

  // Count register; clear wins so the terminal edge and the accept edge both restart at 0.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign terminal_c = (cnt == CNT_W'(LAST));

endmodule

// File: rtl/shift_register.sv
// 8-bit mode-muxed shift register driven by the sequencer.
//   clk    rising-edge clock
//   mode   0: parallel load from p_in, 1: shift left with sin into bit 0
//   sin    serial input
//   p_in   parallel load data
//   sout   serial output (MSB)
//   status current contents
// There is no hold mode and no reset: the sequencer recirculates status to hold
// and loads zero to clear.
module shift_register
  import shift_reg_controller_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] p_in,
  output logic             sout,
  output logic [WIDTH-1:0] status
);

  logic [WIDTH-1:0] q;

  // Storage: either load or shift on every edge.
  always_ff @(posedge clk) begin
    if (mode) begin
      q <= {q[WIDTH-2:0], sin};
    end else begin
      q <= p_in;
    end
  end

  assign sout   = q[WIDTH-1];
  assign status = q;

endmodule

// File: rtl/shift_reg_controller.sv
// Sequencer for one mode-muxed shift register: loads a word on start, shifts it
// out MSB-first while shifting rx_bit in, then pulses done with the received word.
//   clk       rising-edge clock shared with the shift register
//   reset     synchronous, active-high; aborts a transfer and clears the register
//   bus       requester interface (slave side)
//   sr_mode   to shift_register.mode
//   sr_sin    to shift_register.sin
//   sr_p_in   to shift_register.p_in
//   sr_sout   from shift_register.sout
//   sr_status from shift_register.status
module shift_reg_controller
  import shift_reg_controller_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  shift_reg_controller_if.slave   bus,
  output logic                    sr_mode,
  output logic                    sr_sin,
  output logic [WIDTH-1:0]        sr_p_in,
  input  logic                    sr_sout,
  input  logic [WIDTH-1:0]        sr_status
);

  state_t state;
  state_t state_nxt;
  logic   cnt_clear;
  logic   cnt_en;
  logic   cnt_last;

  // Counts shift edges; terminal flag marks the last data bit.
  bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (WIDTH - 1)
  ) u_bit_counter (
    .clk        (clk),
    .clear      (cnt_clear),
    .en         (cnt_en),
    .terminal_c (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and shift-register control. The register has no hold mode, so
  // every non-shifting cycle recirculates status through the load path.
  always_comb begin
    state_nxt = state;
    sr_mode   = 1'b0;
    sr_sin    = 1'b0;
    sr_p_in   = sr_status;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          sr_p_in   = bus.tx_data;
          cnt_clear = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_mode = 1'b1;
        sr_sin  = bus.rx_bit;
        cnt_en  = 1'b1;
        if (cnt_last) begin
          cnt_clear = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Reset overrides everything, including an incoming start, and loads zero.
    if (reset) begin
      sr_mode   = 1'b0;
      sr_sin    = 1'b0;
      sr_p_in   = '0;
      cnt_clear = 1'b1;
      state_nxt = S_IDLE;
    end
  end

  // Handshake outputs decode directly from state; data comes straight from the register.
  assign bus.busy     = state_is_busy(state);
  assign bus.done     = (state == S_DONE);
  assign bus.tx_valid = (state == S_SHIFT);
  assign bus.tx_bit   = sr_sout;
  assign bus.rx_data  = sr_status;

endmodule

// File: tb/tb_shift_reg_controller.sv
// Self-checking bench: sequencer plus one shift_register, table vectors,
// hand-written corner sequences and randomized transfers against a bit-list model.
module tb_shift_reg_controller;
  import shift_reg_controller_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;
  logic sr_mode;
  logic sr_sin;
  logic sr_sout;
  logic [W-1:0] sr_p_in;
  logic [W-1:0] sr_status;

  always #5 clk = ~clk;

  shift_reg_controller_if #(.WIDTH(W)) bus ();

  shift_reg_controller #(.WIDTH(W), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sr_mode   (sr_mode),
    .sr_sin    (sr_sin),
    .sr_p_in   (sr_p_in),
    .sr_sout   (sr_sout),
    .sr_status (sr_status)
  );

  shift_register #(.WIDTH(W)) u_sr (
    .clk    (clk),
    .mode   (sr_mode),
    .sin    (sr_sin),
    .p_in   (sr_p_in),
    .sout   (sr_sout),
    .status (sr_status)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx_stream;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Received word from the list of bits in arrival order: the first bit in
  // ends up as the MSB after W shifts.
  function automatic logic [7:0] model_rx(input logic [7:0] stream);
    bit q[$];
    int v = 0;
    for (int k = 0; k < 8; k++) q.push_back(1'((stream >> (7 - k)) & 8'h01));
    for (int i = 0; i < 8; i++) v += int'(q[i]) * (1 << (7 - i));
    return 8'(v);
  endfunction

  // One full transfer starting at a negedge with the DUT idle; returns at the
  // negedge of the following idle cycle with start low.
  task automatic run_transfer(input string tag, input logic [7:0] tx, input logic [7:0] rx_stream,
                              input logic [7:0] exp_rx, input int glitch_k, input bit noise);
    bus.start   = 1'b1;
    bus.tx_data = tx;
    bus.rx_bit  = 1'($urandom_range(0, 1));
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check({tag, " flags_shift"}, 32'({bus.busy, bus.done, bus.tx_valid}), 32'(3'b101));
      check({tag, " tx_bit"}, 32'(bus.tx_bit), 32'((tx >> (7 - k)) & 8'h01));
      bus.rx_bit = 1'((rx_stream >> (7 - k)) & 8'h01);
      if (k == glitch_k) begin
        bus.start   = 1'b1;
        bus.tx_data = 8'hFF;
      end else if (noise) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.tx_data = 8'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, " flags_done"}, 32'({bus.busy, bus.done, bus.tx_valid}), 32'(3'b110));
    check({tag, " rx_data"}, 32'(bus.rx_data), 32'(exp_rx));
    check({tag, " mode_done"}, 32'(sr_mode), 32'(0));
    bus.start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.tx_data = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " flags_idle"}, 32'({bus.busy, bus.done, bus.tx_valid}), 32'(3'b000));
    check({tag, " hold_after"}, 32'(sr_status), 32'(exp_rx));
  endtask

  initial begin
    int first;
    int second;
    int ndone;
    int nbits;
    int word;
    logic [7:0] tx;
    logic [7:0] rs;

    tbl[0] = '{tx: 8'hA5, rx_stream: 8'h3C, exp_rx: 8'h3C};
    tbl[1] = '{tx: 8'h00, rx_stream: 8'hFF, exp_rx: 8'hFF};
    tbl[2] = '{tx: 8'hFF, rx_stream: 8'h00, exp_rx: 8'h00};
    tbl[3] = '{tx: 8'h81, rx_stream: 8'h96, exp_rx: 8'h96};

    // Reset and reset-over-start with the register preloaded to 0xFF.
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.tx_data = '0;
    bus.rx_bit  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_flags", 32'({bus.busy, bus.done, bus.tx_valid}), 32'(0));
    check("reset_status", 32'(sr_status), 32'(0));
    reset       = 1'b0;
    bus.start   = 1'b1;
    bus.tx_data = 8'hFF;
    @(negedge clk);
    check("preload", 32'(sr_status), 32'hFF);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_clear_status", 32'(sr_status), 32'(0));
    check("reset_clear_flags", 32'({bus.busy, bus.done, bus.tx_valid}), 32'(0));
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("reset_prio_busy", 32'(bus.busy), 32'(0));
    check("reset_prio_status", 32'(sr_status), 32'(0));

    // Table vectors, back-to-back with one idle cycle between.
    for (int i = 0; i < 4; i++)
      run_transfer($sformatf("vec%0d", i), tbl[i].tx, tbl[i].rx_stream, tbl[i].exp_rx, -1, 1'b0);

    // Idle hold for 20 cycles after loading 0x5A.
    run_transfer("load5a", 8'h5A, 8'h5A, 8'h5A, -1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      check("idle_hold_status", 32'(sr_status), 32'h5A);
      check("idle_hold_mode", 32'(sr_mode), 32'(0));
      @(negedge clk);
    end

    // start with 0xFF during shift cycle 3 is ignored; exactly one done.
    rs = 8'($urandom);
    run_transfer("glitch", 8'h81, rs, model_rx(rs), 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("glitch_no_extra_done", 32'({bus.busy, bus.done}), 32'(0));
      @(negedge clk);
    end

    // Reset in shift cycle 4 aborts without a done pulse.
    bus.start   = 1'b1;
    bus.tx_data = 8'hC3;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.rx_bit = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("abort_in_shift", 32'(bus.tx_valid), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    check("abort_flags", 32'({bus.busy, bus.done, bus.tx_valid}), 32'(0));
    check("abort_status", 32'(sr_status), 32'(0));
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'(0));
    run_transfer("after_abort", 8'hA5, 8'h3C, 8'h3C, -1, 1'b0);

    // start held through DONE and the next IDLE: one new transfer, done spacing W+2.
    first       = -1;
    second      = -1;
    ndone       = 0;
    nbits       = 0;
    word        = 0;
    bus.start   = 1'b1;
    bus.tx_data = 8'h3C;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      if (first >= 0 && bus.tx_valid) begin
        word = (word * 2 + int'(bus.tx_bit)) % 256;
        nbits++;
      end
      if (cyc == first) begin
        bus.start   = 1'b1;
        bus.tx_data = 8'h96;
      end else if (first >= 0 && cyc == first + 2) begin
        bus.start = 1'b0;
      end
      bus.rx_bit = 1'($urandom_range(0, 1));
    end
    bus.start = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'(2));
    check("b2b_spacing", 32'(second - first), 32'(W + 2));
    check("b2b_bits", 32'(nbits), 32'(8));
    check("b2b_word", 32'(word), 32'h96);

    // Randomized transfers with start/tx_data noise outside IDLE.
    for (int n = 0; n < 25; n++) begin
      tx = 8'($urandom);
      rs = 8'($urandom);
      run_transfer($sformatf("rand%0d", n), tx, rs, model_rx(rs), -1, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("rand_gap_idle", 32'(bus.busy), 32'(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
